// File: rtl/csr_reg_pkg.sv
// Shared CSR definitions: addresses, field positions, the misa constant,
// and the write-mask / read-mux helpers used by the CSR file.
package csr_reg_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  localparam logic [31:0] MISA_RV32I = 32'h4000_0100;

  // Architectural state held in plain flops (counters live in csr_counter64).
  typedef struct packed {
    logic        mie;
    logic        mpie;
    logic        mtie;
    logic        meie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
  } csr_regs_t;

  typedef struct packed {
    csr_regs_t   regs;
    logic [63:0] mcycle;
    logic [63:0] minstret;
  } csr_state_t;

  // Apply one software write (with masking/forcing) to a state snapshot.
  function automatic csr_state_t csr_write(input csr_state_t s, input logic [11:0] addr,
                                           input logic [31:0] data);
    csr_state_t r;
    r = s;
    case (addr)
      CSR_MSTATUS: begin
        r.regs.mie  = data[MSTATUS_MIE];
        r.regs.mpie = data[MSTATUS_MPIE];
      end
      CSR_MIE: begin
        r.regs.mtie = data[MIE_MTIE];
        r.regs.meie = data[MIE_MEIE];
      end
      CSR_MTVEC:     r.regs.mtvec     = data & 32'hFFFF_FFFC;
      CSR_MSCRATCH:  r.regs.mscratch  = data;
      CSR_MEPC:      r.regs.mepc      = data & 32'hFFFF_FFFC;
      CSR_MCAUSE:    r.regs.mcause    = data;
      CSR_MCYCLE:    r.mcycle[31:0]   = data;
      CSR_MCYCLEH:   r.mcycle[63:32]  = data;
      CSR_MINSTRET:  r.minstret[31:0] = data;
      CSR_MINSTRETH: r.minstret[63:32] = data;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] csr_read(input csr_state_t s, input logic [11:0] addr,
                                           input logic irq_timer, input logic irq_ext,
                                           input logic [31:0] hartid);
    logic [31:0] r;
    r = '0;
    case (addr)
      CSR_MSTATUS: begin
        r[MSTATUS_MIE]  = s.regs.mie;
        r[MSTATUS_MPIE] = s.regs.mpie;
        r[12:11]        = 2'b11;
      end
      CSR_MISA: r = MISA_RV32I;
      CSR_MIE: begin
        r[MIE_MTIE] = s.regs.mtie;
        r[MIE_MEIE] = s.regs.meie;
      end
      CSR_MTVEC:    r = s.regs.mtvec;
      CSR_MSCRATCH: r = s.regs.mscratch;
      CSR_MEPC:     r = s.regs.mepc;
      CSR_MCAUSE:   r = s.regs.mcause;
      CSR_MIP: begin
        r[MIP_MTIP] = irq_timer;
        r[MIP_MEIP] = irq_ext;
      end
      CSR_MCYCLE,   CSR_CYCLE:    r = s.mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   r = s.mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  r = s.minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: r = s.minstret[63:32];
      CSR_MHARTID:  r = hartid;
      default:      r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/csr_reg_if.sv
// CSR access port: write commit from MEM/WB, combinational read for ID/EX.
interface csr_reg_if;
  logic        we_i;
  logic [11:0] waddr_i;
  logic [31:0] wdata_i;
  logic [11:0] raddr_i;
  logic [31:0] rdata_o;

  modport master (output we_i, waddr_i, wdata_i, raddr_i, input rdata_o);
  modport slave  (input we_i, waddr_i, wdata_i, raddr_i, output rdata_o);
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent lo/hi software write ports;
// a write in a cycle replaces the addressed half and suppresses the increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  // NOTE: reset is sampled on the clock edge, and state uses <= so every
  // flop in the design sees pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (we_lo || we_hi) begin
      if (we_lo) count[31:0]  <= wdata;
      if (we_hi) count[63:32] <= wdata;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_reg.sv
// Machine-mode CSR file for the RV32I core: commit of MEM/WB CSR writes,
// forwarded read port, cycle/instret counters, trap/mret state and irq pending.
module csr_reg
  import csr_reg_pkg::*;
#(
  parameter logic [31:0] HARTID      = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  csr_reg_if.slave    bus,
  input  logic        instret_i,
  input  logic        exc_we_i,
  input  logic [31:0] exc_mepc_i,
  input  logic [31:0] exc_mcause_i,
  input  logic        mret_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending_o
);

  csr_regs_t   regs_q, regs_d;
  logic [63:0] mcycle, minstret;
  csr_state_t  cur_view, wr_view, rd_view;
  logic        fwd;

  csr_counter64 u_cycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .we_lo (bus.we_i && bus.waddr_i == CSR_MCYCLE),
    .we_hi (bus.we_i && bus.waddr_i == CSR_MCYCLEH),
    .wdata (bus.wdata_i),
    .count (mcycle)
  );

  csr_counter64 u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instret_i),
    .we_lo (bus.we_i && bus.waddr_i == CSR_MINSTRET),
    .we_hi (bus.we_i && bus.waddr_i == CSR_MINSTRETH),
    .wdata (bus.wdata_i),
    .count (minstret)
  );

  // The software-write view serves both the forwarded read and the commit.
  always_comb begin
    cur_view.regs     = regs_q;
    cur_view.mcycle   = mcycle;
    cur_view.minstret = minstret;
    wr_view           = csr_write(cur_view, bus.waddr_i, bus.wdata_i);
    fwd               = bus.we_i && (bus.waddr_i == bus.raddr_i);
    rd_view           = fwd ? wr_view : cur_view;
  end

  assign bus.rdata_o = csr_read(rd_view, bus.raddr_i, irq_timer_i, irq_ext_i, HARTID);

  // Per-field priority: trap entry beats mret beats the software write.
  always_comb begin
    // NOTE: every path starts from the hold value so no latch is inferred.
    regs_d = regs_q;
    if (bus.we_i) regs_d = wr_view.regs;
    if (mret_i) begin
      regs_d.mie  = regs_q.mpie;
      regs_d.mpie = 1'b1;
    end
    if (exc_we_i) begin
      regs_d.mepc   = exc_mepc_i & 32'hFFFF_FFFC;
      regs_d.mcause = exc_mcause_i;
      regs_d.mpie   = regs_q.mie;
      regs_d.mie    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{mie: 1'b0, mpie: 1'b0, mtie: 1'b0, meie: 1'b0,
                  mtvec: MTVEC_RESET, mscratch: '0, mepc: '0, mcause: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign mtvec_o       = regs_q.mtvec;
  assign mepc_o        = regs_q.mepc;
  assign irq_pending_o = regs_q.mie & ((regs_q.mtie & irq_timer_i) | (regs_q.meie & irq_ext_i));

endmodule

// File: tb/tb_csr_reg.sv
// Self-checking bench for csr_reg: directed scenarios plus randomized traffic
// compared against a behavioural model of the machine-mode CSRs.
module tb_csr_reg;

  localparam logic [31:0] HARTID      = 32'd3;
  localparam logic [31:0] MTVEC_RESET = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        instret, exc_we, mret, irq_timer, irq_ext;
  logic [31:0] exc_mepc, exc_mcause;
  logic [31:0] mtvec_o, mepc_o;
  logic        irq_pending_o;

  int errors = 0;
  int checks = 0;

  csr_reg_if bus ();

  csr_reg #(.HARTID(HARTID), .MTVEC_RESET(MTVEC_RESET)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .instret_i     (instret),
    .exc_we_i      (exc_we),
    .exc_mepc_i    (exc_mepc),
    .exc_mcause_i  (exc_mcause),
    .mret_i        (mret),
    .irq_timer_i   (irq_timer),
    .irq_ext_i     (irq_ext),
    .mtvec_o       (mtvec_o),
    .mepc_o        (mepc_o),
    .irq_pending_o (irq_pending_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic        m_mie, m_mpie;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cycle, m_instret;

  always @(posedge clk) begin : model
    logic old_mie, old_mpie;
    bit   cyc_inc, ins_inc;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mtvec = MTVEC_RESET;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cycle = 0; m_instret = 0;
    end else begin
      old_mie = m_mie; old_mpie = m_mpie;
      cyc_inc = 1; ins_inc = instret;
      if (bus.we_i) begin
        case (bus.waddr_i)
          12'h300: begin m_mie = bus.wdata_i[3]; m_mpie = bus.wdata_i[7]; end
          12'h304: m_mie_reg  = bus.wdata_i & 32'h0000_0880;
          12'h305: m_mtvec    = bus.wdata_i & ~32'd3;
          12'h340: m_mscratch = bus.wdata_i;
          12'h341: m_mepc     = bus.wdata_i & ~32'd3;
          12'h342: m_mcause   = bus.wdata_i;
          12'hB00: begin m_cycle[31:0]    = bus.wdata_i; cyc_inc = 0; end
          12'hB80: begin m_cycle[63:32]   = bus.wdata_i; cyc_inc = 0; end
          12'hB02: begin m_instret[31:0]  = bus.wdata_i; ins_inc = 0; end
          12'hB82: begin m_instret[63:32] = bus.wdata_i; ins_inc = 0; end
          default: ;
        endcase
      end
      if (mret) begin m_mie = old_mpie; m_mpie = 1; end
      if (exc_we) begin
        m_mepc = exc_mepc & ~32'd3; m_mcause = exc_mcause;
        m_mpie = old_mie; m_mie = 0;
      end
      if (cyc_inc) m_cycle = m_cycle + 1;
      if (ins_inc) m_instret = m_instret + 1;
    end
  end

  function automatic logic [31:0] mdl_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie_reg;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0);
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      12'hF14: return HARTID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mdl_expect_rdata();
    logic [31:0] d;
    d = bus.wdata_i;
    if (bus.we_i && bus.waddr_i == bus.raddr_i) begin
      case (bus.raddr_i)
        12'h300: return 32'h1800 | (d & 32'h88);
        12'h304: return d & 32'h880;
        12'h305, 12'h341: return d & ~32'd3;
        12'h340, 12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82: return d;
        default: return mdl_read(bus.raddr_i);
      endcase
    end
    return mdl_read(bus.raddr_i);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we_i = 0; bus.waddr_i = 0; bus.wdata_i = 0; bus.raddr_i = 0;
    instret = 0; exc_we = 0; mret = 0; exc_mepc = 0; exc_mcause = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; idle(); irq_timer = 0; irq_ext = 0;
    repeat (2) tick();
    rst = 0;
    bus.raddr_i = 12'h300; #1; checks++;
    if (bus.rdata_o !== 32'h0000_1800) begin errors++; $display("FAIL reset_mstatus: got %h want %h", bus.rdata_o, 32'h1800); end
    bus.raddr_i = 12'h305; #1; checks++;
    if (bus.rdata_o !== MTVEC_RESET) begin errors++; $display("FAIL reset_mtvec: got %h want %h", bus.rdata_o, MTVEC_RESET); end
    bus.raddr_i = 12'hB00; #1; checks++;
    if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL reset_mcycle: got %h want 0", bus.rdata_o); end
    bus.raddr_i = 12'hF14; #1; checks++;
    if (bus.rdata_o !== HARTID) begin errors++; $display("FAIL reset_mhartid: got %h want %h", bus.rdata_o, HARTID); end
    checks++;
    if (irq_pending_o !== 1'b0 || mepc_o !== 32'h0 || mtvec_o !== MTVEC_RESET) begin
      errors++; $display("FAIL reset_outputs: irq=%b mepc=%h mtvec=%h", irq_pending_o, mepc_o, mtvec_o);
    end
  endtask

  task automatic test_forward_mepc();
    tick();
    bus.we_i = 1; bus.waddr_i = 12'h341; bus.wdata_i = 32'h8000_0007; bus.raddr_i = 12'h341;
    #1; checks++;
    if (bus.rdata_o !== 32'h8000_0004) begin errors++; $display("FAIL fwd_mepc: got %h want 80000004", bus.rdata_o); end
    tick();
    bus.we_i = 0; #1; checks++;
    if (mepc_o !== 32'h8000_0004 || bus.rdata_o !== 32'h8000_0004) begin
      errors++; $display("FAIL mepc_commit: mepc_o=%h rdata=%h want 80000004", mepc_o, bus.rdata_o);
    end
  endtask

  task automatic test_counter_wrap();
    bus.we_i = 1; bus.waddr_i = 12'hB00; bus.wdata_i = 32'hFFFF_FFFE; tick();
    bus.waddr_i = 12'hB80; bus.wdata_i = 32'hFFFF_FFFF; tick();
    bus.we_i = 0;
    bus.raddr_i = 12'hC00; #1; checks++;
    if (bus.rdata_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cyc_written_lo: got %h want fffffffe", bus.rdata_o); end
    bus.raddr_i = 12'hC80; #1; checks++;
    if (bus.rdata_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cyc_written_hi: got %h want ffffffff", bus.rdata_o); end
    tick(); tick();
    bus.raddr_i = 12'hC00; #1; checks++;
    if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL cyc_wrap_lo: got %h want 0", bus.rdata_o); end
    bus.raddr_i = 12'hC80; #1; checks++;
    if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL cyc_wrap_hi: got %h want 0", bus.rdata_o); end
    tick();
    bus.raddr_i = 12'hC00; #1; checks++;
    if (bus.rdata_o !== 32'h1) begin errors++; $display("FAIL cyc_after_wrap: got %h want 1", bus.rdata_o); end
  endtask

  task automatic test_irq_trap();
    bus.we_i = 1; bus.waddr_i = 12'h300; bus.wdata_i = 32'h8; tick();
    bus.waddr_i = 12'h304; bus.wdata_i = 32'h800; tick();
    bus.we_i = 0; irq_ext = 1; #1; checks++;
    if (irq_pending_o !== 1'b1) begin errors++; $display("FAIL irq_pending_set: got %b want 1", irq_pending_o); end
    exc_we = 1; exc_mcause = 32'h8000_000B; exc_mepc = 32'h0000_1234; tick();
    exc_we = 0; bus.raddr_i = 12'h300; #1; checks++;
    if (bus.rdata_o !== 32'h1880 || irq_pending_o !== 1'b0) begin
      errors++; $display("FAIL trap_entry: mstatus=%h irq=%b want 1880/0", bus.rdata_o, irq_pending_o);
    end
    bus.raddr_i = 12'h342; #1; checks++;
    if (bus.rdata_o !== 32'h8000_000B) begin errors++; $display("FAIL trap_mcause: got %h want 8000000b", bus.rdata_o); end
    mret = 1; tick();
    mret = 0; bus.raddr_i = 12'h300; #1; checks++;
    if (bus.rdata_o !== 32'h1888 || irq_pending_o !== 1'b1) begin
      errors++; $display("FAIL mret: mstatus=%h irq=%b want 1888/1", bus.rdata_o, irq_pending_o);
    end
    irq_ext = 0; #1; checks++;
    if (irq_pending_o !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b want 0", irq_pending_o); end
  endtask

  task automatic test_priority();
    exc_we = 1; exc_mepc = 32'h100; exc_mcause = 32'h2;
    bus.we_i = 1; bus.waddr_i = 12'h341; bus.wdata_i = 32'h200; tick();
    exc_we = 0; bus.we_i = 0; bus.raddr_i = 12'h341; #1; checks++;
    if (bus.rdata_o !== 32'h100) begin errors++; $display("FAIL exc_over_write: mepc=%h want 100", bus.rdata_o); end
    exc_we = 1; exc_mepc = 32'h300;
    bus.we_i = 1; bus.waddr_i = 12'h340; bus.wdata_i = 32'hCAFE_F00D; tick();
    exc_we = 0; bus.we_i = 0; bus.raddr_i = 12'h340; #1; checks++;
    if (bus.rdata_o !== 32'hCAFE_F00D || mepc_o !== 32'h300) begin
      errors++; $display("FAIL exc_with_mscratch: mscratch=%h mepc=%h want cafef00d/300", bus.rdata_o, mepc_o);
    end
    // Two traps left MIE=0, MPIE=0; mret must beat the concurrent mstatus write.
    mret = 1; bus.we_i = 1; bus.waddr_i = 12'h300; bus.wdata_i = 32'h88; tick();
    mret = 0; bus.we_i = 0; bus.raddr_i = 12'h300; #1; checks++;
    if (bus.rdata_o !== 32'h1880) begin errors++; $display("FAIL mret_over_write: mstatus=%h want 1880", bus.rdata_o); end
  endtask

  task automatic test_reset_mid();
    bus.we_i = 1; bus.waddr_i = 12'h340; bus.wdata_i = 32'hABCD; tick();
    rst = 1; bus.wdata_i = 32'h1111; instret = 1; tick();
    rst = 0; bus.we_i = 0; instret = 0;
    bus.raddr_i = 12'h340; #1; checks++;
    if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL rst_mscratch: got %h want 0", bus.rdata_o); end
    bus.raddr_i = 12'hB02; #1; checks++;
    if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL rst_minstret: got %h want 0", bus.rdata_o); end
    bus.raddr_i = 12'h300; #1; checks++;
    if (bus.rdata_o !== 32'h1800 || mtvec_o !== MTVEC_RESET) begin
      errors++; $display("FAIL rst_state: mstatus=%h mtvec=%h", bus.rdata_o, mtvec_o);
    end
  endtask

  logic [11:0] addrs [19] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                              12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h000};

  task automatic test_random();
    logic [31:0] exp_rdata;
    logic        exp_irq;
    for (int i = 0; i < 500; i++) begin
      tick();
      rst           = ($urandom_range(0, 79) == 0);
      bus.we_i      = 1'($urandom_range(0, 1));
      bus.waddr_i   = addrs[$urandom_range(0, 18)];
      bus.wdata_i   = $urandom;
      bus.raddr_i   = ($urandom_range(0, 2) == 0) ? bus.waddr_i : addrs[$urandom_range(0, 18)];
      instret       = 1'($urandom_range(0, 1));
      exc_we        = ($urandom_range(0, 9) == 0);
      mret          = ($urandom_range(0, 9) == 0);
      exc_mepc      = $urandom;
      exc_mcause    = $urandom;
      irq_timer     = 1'($urandom_range(0, 1));
      irq_ext       = 1'($urandom_range(0, 1));
      #1;
      exp_rdata = mdl_expect_rdata();
      exp_irq   = m_mie & ((m_mie_reg[7] & irq_timer) | (m_mie_reg[11] & irq_ext));
      checks++;
      if (bus.rdata_o !== exp_rdata) begin
        errors++; $display("FAIL rand_rdata[%0d] addr=%h: got %h want %h", i, bus.raddr_i, bus.rdata_o, exp_rdata);
      end
      checks++;
      if (mtvec_o !== m_mtvec || mepc_o !== m_mepc) begin
        errors++; $display("FAIL rand_vec[%0d]: mtvec=%h/%h mepc=%h/%h", i, mtvec_o, m_mtvec, mepc_o, m_mepc);
      end
      checks++;
      if (irq_pending_o !== exp_irq) begin
        errors++; $display("FAIL rand_irq[%0d]: got %b want %b", i, irq_pending_o, exp_irq);
      end
    end
    rst = 0; idle();
  endtask

  initial begin
    test_reset();
    test_forward_mepc();
    test_counter_wrap();
    test_irq_trap();
    test_priority();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
